// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline and a FIFO of LU results
module wb_port_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pipe_wb_en,
  input  logic [3:0]       pipe_wb_addr,
  input  logic [31:0]      pipe_wb_data,
  output logic             pipe_stall,
  input  logic             lu_valid,
  output logic             lu_ready,
  input  logic [3:0]       lu_addr,
  input  logic [31:0]      lu_data,
  output logic             wport_enable,
  output logic [3:0]       wport_addr,
  output logic [31:0]      wport_data,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT);
  logic [DEPTH-1:0] ent_valid;
  logic [3:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [WW-1:0]    wait_cnt;
  logic             empty, push, pipe_grant, fifo_grant, head_write, wait_max;
  assign empty      = fifo_count == '0;
  assign lu_ready   = fifo_count != CNT_W'(DEPTH);
  assign push       = lu_valid & lu_ready;
  // a stall cycle belongs to the FIFO; the pipeline re-presents its write afterwards
  assign pipe_grant = pipe_wb_en & ~pipe_stall;
  assign fifo_grant = ~empty & (pipe_stall | ~pipe_wb_en);
  assign head_write = fifo_grant & ent_valid[rd_ptr];
  assign wait_max   = wait_cnt == WW'(MAX_WAIT - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent_valid    <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      fifo_count   <= '0;
      wait_cnt     <= '0;
      pipe_stall   <= 1'b0;
      wport_enable <= 1'b0;
      wport_addr   <= '0;
      wport_data   <= '0;
    end else begin
      // younger pipeline write supersedes queued LU results to the same register
      for (int i = 0; i < DEPTH; i++)
        if (pipe_grant && ent_addr[i] == pipe_wb_addr) ent_valid[i] <= 1'b0;
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        ent_addr[wr_ptr]  <= lu_addr;
        ent_data[wr_ptr]  <= lu_data;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (fifo_grant) rd_ptr <= rd_ptr + PW'(1);
      fifo_count   <= fifo_count + CNT_W'(push) - CNT_W'(fifo_grant);
      wait_cnt     <= (empty || fifo_grant) ? '0 : wait_max ? wait_cnt : wait_cnt + WW'(1);
      pipe_stall   <= ~empty & ~fifo_grant & wait_max;
      wport_enable <= pipe_grant | head_write;
      if (pipe_grant) begin
        wport_addr <= pipe_wb_addr;
        wport_data <= pipe_wb_data;
      end else if (head_write) begin
        wport_addr <= ent_addr[rd_ptr];
        wport_data <= ent_data[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed scoreboard bench for wb_port_arbiter
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_wb_en;
  logic [3:0]  pipe_wb_addr;
  logic [31:0] pipe_wb_data;
  logic        pipe_stall;
  logic        lu_valid;
  logic        lu_ready;
  logic [3:0]  lu_addr;
  logic [31:0] lu_data;
  logic        wport_enable;
  logic [3:0]  wport_addr;
  logic [31:0] wport_data;
  logic [2:0]  fifo_count;
  int          vectors = 0;
  int          miscompares = 0;
  logic [35:0] exp_q [$];
  logic [31:0] rf [16];

  wb_port_arbiter #(.DEPTH(4), .MAX_WAIT(8), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
    .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .wport_enable(wport_enable), .wport_addr(wport_addr), .wport_data(wport_data),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic pe, input logic [3:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [3:0] la, input logic [31:0] ld);
    pipe_wb_en = pe; pipe_wb_addr = pa; pipe_wb_data = pd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] wr(input logic [3:0] a, input logic [31:0] d);
    return {a, d};
  endfunction

  // monitor: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    logic [35:0] e;
    if (wport_enable === 1'b1) begin
      vectors++;
      rf[wport_addr] = wport_data;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got r%0d=%h expected no write", wport_addr, wport_data);
      end else begin
        e = exp_q.pop_front();
        if ({wport_addr, wport_data} !== e) begin
          miscompares++;
          $display("FAIL write: got r%0d=%h expected r%0d=%h", wport_addr, wport_data, e[35:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drive(1, 4'd5, 32'h1, 1, 4'd6, 32'h2);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_wen", wport_enable, 0);
      chk("rst_count", fifo_count, 0);
      chk("rst_stall", pipe_stall, 0);
    end
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rst_lu_ready", lu_ready, 1);
    chk("rst_wport_addr", wport_addr, 0);

    // idle drain
    drive(0, 0, 0, 1, 4'd3, 32'hA5A5A5A5);
    exp_q.push_back(wr(4'd3, 32'hA5A5A5A5));
    step();
    chk("drain_count1", fifo_count, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("drain_wen", wport_enable, 1);
    chk("drain_count0", fifo_count, 0);

    // pipeline priority over queued LU result
    drive(1, 4'd5, 32'h22, 1, 4'd4, 32'h11);
    for (int i = 0; i < 3; i++) exp_q.push_back(wr(4'd5, 32'h22));
    exp_q.push_back(wr(4'd4, 32'h11));
    step();
    drive(1, 4'd5, 32'h22, 0, 0, 0);
    step();
    step();
    chk("prio_count1", fifo_count, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("prio_count0", fifo_count, 0);

    // kill: younger pipeline write to r7 cancels queued r7
    drive(0, 0, 0, 1, 4'd7, 32'hDEAD);
    step();
    drive(1, 4'd7, 32'hBEEF, 0, 0, 0);
    exp_q.push_back(wr(4'd7, 32'hBEEF));
    step();
    chk("kill_count1", fifo_count, 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("kill_count0", fifo_count, 0);
    chk("kill_no_write", wport_enable, 0);

    // starvation: eight ungranted cycles, then a single forced stall
    drive(1, 4'd9, 32'h900, 1, 4'd2, 32'h1234);
    exp_q.push_back(wr(4'd9, 32'h900));
    step();
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("starve_nostall%0d", k), pipe_stall, 0);
      drive(1, 4'd9, 32'h900 + k, 0, 0, 0);
      exp_q.push_back(wr(4'd9, 32'h900 + k));
      step();
    end
    chk("starve_stall", pipe_stall, 1);
    drive(1, 4'd9, 32'h909, 0, 0, 0);
    exp_q.push_back(wr(4'd2, 32'h1234));
    step();
    chk("starve_stall_end", pipe_stall, 0);
    chk("starve_count0", fifo_count, 0);
    exp_q.push_back(wr(4'd9, 32'h909));
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();

    // full FIFO with busy pipeline, then drain and refill across pointer wrap
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("full_ready%0d", k), lu_ready, 1);
      drive(1, 4'd1, 32'h1000 + k, 1, 4'(8 + k), 32'hA0 + k);
      exp_q.push_back(wr(4'd1, 32'h1000 + k));
      step();
    end
    chk("full_count4", fifo_count, 4);
    chk("full_not_ready", lu_ready, 0);
    drive(1, 4'd1, 32'h1004, 1, 4'd12, 32'hEE);
    exp_q.push_back(wr(4'd1, 32'h1004));
    step();
    chk("full_held_off", fifo_count, 4);
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) exp_q.push_back(wr(4'(8 + k), 32'hA0 + k));
    step();
    chk("full_count3", fifo_count, 3);
    step();
    chk("full_count2", fifo_count, 2);
    for (int k = 4; k < 8; k++) begin
      drive(0, 0, 0, 1, 4'(8 + k), 32'hA0 + k);
      if (k >= 6) exp_q.push_back(wr(4'(8 + k), 32'hA0 + k));
      step();
      chk($sformatf("wrap_count%0d", k), fifo_count, 2);
    end
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("wrap_count0", fifo_count, 0);
    step();
    step();
    chk("all_writes_seen", exp_q.size(), 0);
    chk("rf_r7", rf[7], 32'hBEEF);
    chk("rf_r2", rf[2], 32'h1234);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
